// File: rtl/rcv_cu_pkg.sv
// Shared definitions for the UART receive control unit: FSM encoding and the
// byte/sample widths that the transmit control unit also relies on.
package rcv_cu_pkg;

   localparam int BYTE_W   = 8;
   localparam int SAMPLE_W = 16;

   // 2'b11 is unused and recovers to WAIT_LSB.
   typedef enum logic [1:0] {
      WAIT_LSB = 2'b00,
      WAIT_MSB = 2'b01,
      HOLD     = 2'b10
   } rcv_state_e;

endpackage : rcv_cu_pkg

// File: rtl/rcv_cu_if.sv
// Byte-in / sample-out bundle between the UART receiver, the receive control
// unit and the FIR input. "slave" is the control unit, "master" its environment.
interface rcv_cu_if #(
   parameter int OVR_CNT_W = 8
);
   import rcv_cu_pkg::*;

   logic                   RxD_data_ready;
   logic [BYTE_W-1:0]      RxD_data;
   logic                   FIR_ready;
   logic [SAMPLE_W-1:0]    FIR_in;
   logic                   FIR_in_valid;
   logic                   overrun;
   logic [OVR_CNT_W-1:0]   ovr_cnt;
   logic                   timeout;

   modport master (
      output RxD_data_ready, RxD_data, FIR_ready,
      input  FIR_in, FIR_in_valid, overrun, ovr_cnt, timeout
   );

   modport slave (
      input  RxD_data_ready, RxD_data, FIR_ready,
      output FIR_in, FIR_in_valid, overrun, ovr_cnt, timeout
   );

endinterface : rcv_cu_if

// File: rtl/rcv_cu_sat_counter.sv
// Parameterised-width saturating incrementer with synchronous active-low clear;
// holds at all-ones once reached.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : sat_counter

// File: rtl/rcv_cu.sv
// Receive control unit: pairs UART bytes (LSB then MSB) into 16-bit FIR samples
// with valid/ready hand-off. Define RCV_TIMEOUT_EN to add the inter-byte timeout.
module rcv_cu
   import rcv_cu_pkg::*;
#(
   parameter int DATA_W      = SAMPLE_W,
   parameter int TIMEOUT_CYC = 100000,
   parameter int OVR_CNT_W   = 8
) (
   input  logic    clk,
   input  logic    rst,
   rcv_cu_if.slave bus
);

   rcv_state_e             state_q;
   rcv_state_e             state_d;
   logic [BYTE_W-1:0]      lsb_q;
   logic [BYTE_W-1:0]      lsb_d;
   logic [DATA_W-1:0]      fir_in_q;
   logic [DATA_W-1:0]      fir_in_d;
   logic                   fir_in_valid_q;
   logic                   fir_in_valid_d;
   logic                   overrun_q;
   logic                   overrun_d;
   logic                   timeout_q;
   logic                   timeout_d;
   logic                   ovr_inc;
   logic                   tmo_hit;
   logic [OVR_CNT_W-1:0]   ovr_cnt;

   always_comb begin
      state_d        = state_q;
      lsb_d          = lsb_q;
      fir_in_d       = fir_in_q;
      fir_in_valid_d = fir_in_valid_q;
      overrun_d      = 1'b0;
      timeout_d      = 1'b0;
      ovr_inc        = 1'b0;

      case (state_q)
         WAIT_LSB: begin
            if (bus.RxD_data_ready) begin
               lsb_d   = bus.RxD_data;
               state_d = WAIT_MSB;
            end
         end
         WAIT_MSB: begin
            // A strobe arriving on the expiry cycle is taken as the MSB.
            if (bus.RxD_data_ready) begin
               fir_in_d       = {bus.RxD_data, lsb_q};
               fir_in_valid_d = 1'b1;
               state_d        = HOLD;
            end else if (tmo_hit) begin
               timeout_d = 1'b1;
               state_d   = WAIT_LSB;
            end
         end
         HOLD: begin
            if (bus.FIR_ready) begin
               fir_in_valid_d = 1'b0;
               if (bus.RxD_data_ready) begin
                  lsb_d   = bus.RxD_data;
                  state_d = WAIT_MSB;
               end else begin
                  state_d = WAIT_LSB;
               end
            end else if (bus.RxD_data_ready) begin
               overrun_d = 1'b1;
               ovr_inc   = 1'b1;
            end
         end
         default: begin
            fir_in_valid_d = 1'b0;
            state_d        = WAIT_LSB;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= WAIT_LSB;
         lsb_q          <= '0;
         fir_in_q       <= '0;
         fir_in_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         lsb_q          <= lsb_d;
         fir_in_q       <= fir_in_d;
         fir_in_valid_q <= fir_in_valid_d;
         overrun_q      <= overrun_d;
         timeout_q      <= timeout_d;
      end
   end

   sat_counter #(
      .W(OVR_CNT_W)
   ) u_ovr_cnt (
      .clk   (clk),
      .clr_n (rst),
      .inc   (ovr_inc),
      .count (ovr_cnt)
   );

`ifdef RCV_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_clr_n;
   logic             tmo_inc;

   // Restart the count on every entry into WAIT_MSB, from either direction.
   assign tmo_clr_n = rst && !((state_d == WAIT_MSB) && (state_q != WAIT_MSB));
   assign tmo_inc   = (state_q == WAIT_MSB);

   sat_counter #(
      .W(TMO_W)
   ) u_tmo_cnt (
      .clk   (clk),
      .clr_n (tmo_clr_n),
      .inc   (tmo_inc),
      .count (tmo_cnt)
   );

   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
   assign tmo_hit            = 1'b0;
`endif

   assign bus.FIR_in       = fir_in_q;
   assign bus.FIR_in_valid = fir_in_valid_q;
   assign bus.overrun      = overrun_q;
   assign bus.ovr_cnt      = ovr_cnt;
   assign bus.timeout      = timeout_q;

endmodule : rcv_cu

// File: tb/tb_rcv_cu.sv
// Bench for rcv_cu: directed scenarios plus randomized traffic, every cycle
// compared against a flag-level model of the byte pairing rules.
module tb_rcv_cu;
   localparam int OVR_W   = 2;
   localparam int TMO_CYC = 10;
   localparam int OVR_MAX = (1 << OVR_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;

   rcv_cu_if #(.OVR_CNT_W(OVR_W)) bus ();

   rcv_cu #(
      .DATA_W      (16),
      .TIMEOUT_CYC (TMO_CYC),
      .OVR_CNT_W   (OVR_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: do we hold a sample, do we have a lone LSB, and how long
   // have we been waiting for its MSB.
   bit          m_held;
   bit          m_partial;
   logic [7:0]  m_lsb;
   logic [15:0] m_sample;
   int          m_wait;
   int          m_cnt;
   bit          m_ovr;
   bit          m_tmo;
   bit          tmo_enabled;

   int ovr_seen;
   int tmo_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_update(input bit r_n, input bit rdy, input logic [7:0] d, input bit fr);
      m_ovr = 1'b0;
      m_tmo = 1'b0;
      if (!r_n) begin
         m_held = 0; m_partial = 0; m_lsb = 8'h00; m_sample = 16'h0000;
         m_wait = 0; m_cnt = 0;
      end else if (m_held) begin
         if (fr) begin
            $display("TXN accepted sample 0x%04h", m_sample);
            m_held = 0;
            if (rdy) begin
               m_partial = 1; m_lsb = d; m_wait = 0;
            end
         end else if (rdy) begin
            m_ovr = 1;
            if (m_cnt < OVR_MAX) m_cnt++;
         end
      end else if (m_partial) begin
         if (rdy) begin
            m_sample  = {d, m_lsb};
            m_held    = 1;
            m_partial = 0;
         end else if (tmo_enabled && m_wait == TMO_CYC - 1) begin
            m_partial = 0;
            m_tmo     = 1;
         end else begin
            m_wait++;
         end
      end else if (rdy) begin
         m_partial = 1; m_lsb = d; m_wait = 0;
      end
   endtask

   task automatic step(input bit r_n, input bit rdy, input logic [7:0] d, input bit fr);
      @(negedge clk);
      rst                = r_n;
      bus.RxD_data_ready = rdy;
      bus.RxD_data       = d;
      bus.FIR_ready      = fr;
      @(posedge clk);
      model_update(r_n, rdy, d, fr);
      #1;
      check("valid",   32'(bus.FIR_in_valid), 32'(m_held));
      check("fir_in",  32'(bus.FIR_in),       32'(m_sample));
      check("overrun", 32'(bus.overrun),      32'(m_ovr));
      check("ovr_cnt", 32'(bus.ovr_cnt),      32'(m_cnt));
      check("timeout", 32'(bus.timeout),      32'(m_tmo));
      if (bus.overrun) ovr_seen++;
      if (bus.timeout) tmo_seen++;
   endtask

   task automatic do_reset();
      step(0, 0, 8'h00, 0);
      ovr_seen = 0;
      tmo_seen = 0;
   endtask

   initial begin
`ifdef RCV_TIMEOUT_EN
      tmo_enabled = 1'b1;
`else
      tmo_enabled = 1'b0;
`endif
      bus.RxD_data_ready = 1'b0;
      bus.RxD_data       = 8'h00;
      bus.FIR_ready      = 1'b0;

      // Reset state
      do_reset();
      do_reset();
      check("rst_fir_in", 32'(bus.FIR_in), 32'h0);
      check("rst_ovr_cnt", 32'(bus.ovr_cnt), 32'h0);

      // Basic assembly with FIR always ready: valid for exactly one cycle
      step(1, 1, 8'h34, 1);
      step(1, 0, 8'h00, 1);
      step(1, 1, 8'h12, 1);
      check("basic_sample", 32'(bus.FIR_in), 32'h1234);
      check("basic_valid", 32'(bus.FIR_in_valid), 32'h1);
      step(1, 0, 8'h00, 1);
      check("basic_one_cycle", 32'(bus.FIR_in_valid), 32'h0);

      // Backpressure and a single overrun
      do_reset();
      step(1, 1, 8'hCD, 0);
      step(1, 1, 8'hAB, 0);
      step(1, 0, 8'h00, 0);
      step(1, 1, 8'hFF, 0);
      step(1, 0, 8'h00, 0);
      check("bp_hold", 32'(bus.FIR_in), 32'hABCD);
      check("bp_ovr_pulses", 32'(ovr_seen), 32'd1);
      check("bp_ovr_cnt", 32'(bus.ovr_cnt), 32'd1);
      step(1, 0, 8'h00, 1);
      check("bp_valid_drop", 32'(bus.FIR_in_valid), 32'h0);

      // Accept and new LSB on the same cycle
      do_reset();
      step(1, 1, 8'hEF, 0);
      step(1, 1, 8'hBE, 0);
      step(1, 1, 8'h01, 1);
      check("simul_accept", 32'(bus.FIR_in_valid), 32'h0);
      step(1, 1, 8'h02, 0);
      check("simul_sample", 32'(bus.FIR_in), 32'h0201);

      // Overrun counter saturation
      do_reset();
      step(1, 1, 8'h01, 0);
      step(1, 1, 8'h02, 0);
      for (int i = 0; i < 5; i++) step(1, 1, 8'(i), 0);
      step(1, 0, 8'h00, 0);
      check("sat_pulses", 32'(ovr_seen), 32'd5);
      check("sat_cnt", 32'(bus.ovr_cnt), 32'(OVR_MAX));

      // Inter-byte timeout window
      do_reset();
      step(1, 1, 8'h55, 1);
      for (int i = 0; i < TMO_CYC; i++) step(1, 0, 8'h00, 1);
      step(1, 0, 8'h00, 1);
      check("tmo_pulses", 32'(tmo_seen), tmo_enabled ? 32'd1 : 32'd0);
      step(1, 1, 8'h11, 0);
      step(1, 1, 8'h22, 0);
      check("tmo_after", 32'(bus.FIR_in), tmo_enabled ? 32'h2211 : 32'h1155);

      // Reset in the middle of a pair
      do_reset();
      step(1, 1, 8'h77, 0);
      do_reset();
      check("midrst_valid", 32'(bus.FIR_in_valid), 32'h0);
      step(1, 1, 8'h11, 0);
      step(1, 1, 8'h22, 0);
      check("midrst_sample", 32'(bus.FIR_in), 32'h2211);

      // Randomized traffic with varying strobe density and occasional resets
      for (int blk = 0; blk < 30; blk++) begin
         int p_rdy;
         int p_fr;
         p_rdy = int'($urandom_range(3, 60));
         p_fr  = int'($urandom_range(10, 90));
         for (int c = 0; c < 100; c++) begin
            bit r_n;
            bit rdy;
            bit fr;
            r_n = ($urandom_range(0, 249) != 0);
            rdy = (int'($urandom_range(0, 99)) < p_rdy);
            fr  = (int'($urandom_range(0, 99)) < p_fr);
            step(r_n, rdy, 8'($urandom), fr);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_rcv_cu
